// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//   Serial-to-parallel capture of up to N bits, MSB-first or LSB-first.
//   A capture starts on i_start: the word and bit counter clear, and the
//   direction and the clamped bit count min(i_iterations, N) are latched.
//   Bits are accepted only while receiving and only when i_valid is high.
//
//   Optional feature macro: DESERIALIZER_PARITY_EN
//     defined   : one extra valid bit after the data is taken as even parity;
//                 o_parity_error reports XOR(data, parity) from DONE onwards
//                 and holds until the next i_start.
//     undefined : data bits only; o_parity_error stays 0.
//
// Ports
//   i_clock        sole clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_start        begin (or restart) a capture
//   i_direction    1 = MSB first, 0 = LSB first (sampled with i_start)
//   i_iterations   number of data bits (sampled with i_start, clamped to N)
//   i_valid        qualifies i_bit
//   i_bit          serial data bit
//   o_value        assembled word, held from DONE until the next i_start
//   o_busy         high while in RECEIVE
//   o_finished     one-cycle pulse in DONE
//   o_parity_error parity check result
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for i_start; word and parity result held
// RECEIVE | accepting valid bits until the latched count is reached
// DONE    | single-cycle completion pulse, then back to IDLE
// -----------------------------------------------------------------------------
module deserializer #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_direction,
  input  logic [N-1:0] i_iterations,
  input  logic         i_valid,
  input  logic         i_bit,
  output logic [N-1:0] o_value,
  output logic         o_busy,
  output logic         o_finished,
  output logic         o_parity_error
);

  // Counter must reach N data bits plus an optional parity bit.
  localparam int CW = $clog2(N + 2);
  localparam logic [N-1:0] N_VEC = N'(N);

`ifdef DESERIALIZER_PARITY_EN
  localparam logic [CW-1:0] EXTRA = CW'(1);
`else
  localparam logic [CW-1:0] EXTRA = CW'(0);
`endif

  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          dir_q, dir_d;
  logic          par_q, par_d;
  logic          perr_q, perr_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic [CW-1:0] start_len;
  logic [CW-1:0] total_bits;

  always_comb begin
    start_len  = (i_iterations > N_VEC) ? CW'(N) : CW'(i_iterations);
    // A zero-length capture skips the parity bit as well.
    total_bits = (len_q == '0) ? '0 : len_q + EXTRA;

    state_d = state_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dir_d   = dir_q;
    par_d   = par_q;
    perr_d  = perr_q;
    busy_d  = 1'b0;
    fin_d   = 1'b0;

    if (i_start) begin
      // Start wins over any bit presented in the same cycle.
      value_d = '0;
      cnt_d   = '0;
      len_d   = start_len;
      dir_d   = i_direction;
      par_d   = 1'b0;
      perr_d  = 1'b0;
      if (start_len == '0) begin
        state_d = DONE;
        fin_d   = 1'b1;
      end else begin
        state_d = RECEIVE;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RECEIVE: begin
          busy_d = 1'b1;
          if (i_valid) begin
            cnt_d = cnt_q + CW'(1);
            par_d = par_q ^ i_bit;
            // Bits beyond the data count are the parity bit, never stored.
            if (cnt_q < len_q) begin
              if (dir_q) begin
                value_d = {value_q[N-2:0], i_bit};
              end else begin
                for (int i = 0; i < N; i++) begin
                  if (cnt_q == CW'(i)) value_d[i] = i_bit;
                end
              end
            end
            if (cnt_d == total_bits) begin
              state_d = DONE;
              busy_d  = 1'b0;
              fin_d   = 1'b1;
              perr_d  = (EXTRA != '0) && par_d;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      value_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign o_value        = value_q;
  assign o_busy         = busy_q;
  assign o_finished     = fin_q;
  assign o_parity_error = perr_q;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  localparam int N = 8;

`ifdef DESERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic         i_direction;
  logic [N-1:0] i_iterations;
  logic         i_valid;
  logic         i_bit;
  logic [N-1:0] o_value;
  logic         o_busy;
  logic         o_finished;
  logic         o_parity_error;

  int total = 0;
  int bad   = 0;

  deserializer #(.N(N)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_direction    (i_direction),
    .i_iterations   (i_iterations),
    .i_valid        (i_valid),
    .i_bit          (i_bit),
    .o_value        (o_value),
    .o_busy         (o_busy),
    .o_finished     (o_finished),
    .o_parity_error (o_parity_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference word: k-th accepted bit lands at weight len-1-k (MSB first)
  // or weight k (LSB first).
  function automatic logic [N-1:0] model_word(input logic dir, input int len,
                                              input logic [15:0] bits);
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < len; k++) begin
      if (bits[k]) w = w | (N'(1) << (dir ? (len - 1 - k) : k));
    end
    return w;
  endfunction

  task automatic capture(input logic dir, input int iter, input logic [15:0] bits,
                         input bit gaps, input bit flip, input string tag,
                         output logic [N-1:0] got);
    int           len;
    int           nbits;
    logic         dpar;
    logic [N-1:0] exp_w;
    logic         exp_perr;
    len   = (iter > N) ? N : iter;
    exp_w = model_word(dir, len, bits);
    dpar  = 1'b0;
    for (int k = 0; k < len; k++) dpar ^= bits[k];
    nbits    = len + ((PAR_EN && len > 0) ? 1 : 0);
    exp_perr = PAR_EN && (len > 0) && flip;

    // Valid bit alongside start must be discarded.
    i_start      = 1'b1;
    i_direction  = dir;
    i_iterations = N'(iter);
    i_valid      = 1'b1;
    i_bit        = 1'b1;
    step();
    i_start = 1'b0;
    i_valid = 1'b0;
    chk({tag, "_clear"}, o_value, 0);
    if (nbits == 0) begin
      chk({tag, "_fin0"}, o_finished, 1);
      chk({tag, "_busy0"}, o_busy, 0);
    end else begin
      chk({tag, "_busy_start"}, o_busy, 1);
      chk({tag, "_fin_start"}, o_finished, 0);
    end

    for (int k = 0; k < nbits; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++) begin
          i_valid = 1'b0;
          i_bit   = 1'($urandom);
          step();
          chk({tag, "_busy_gap"}, o_busy, 1);
        end
      end
      i_valid = 1'b1;
      i_bit   = (k < len) ? bits[k] : (dpar ^ flip);
      step();
      i_valid = 1'b0;
      if (k < nbits - 1) begin
        chk({tag, "_busy_bit"}, o_busy, 1);
        chk({tag, "_fin_early"}, o_finished, 0);
      end else begin
        chk({tag, "_fin"}, o_finished, 1);
        chk({tag, "_busy_done"}, o_busy, 0);
      end
    end

    chk({tag, "_value"}, o_value, exp_w);
    chk({tag, "_perr"}, o_parity_error, exp_perr);

    // Valid bits outside RECEIVE must not disturb the result.
    i_valid = 1'b1;
    i_bit   = 1'($urandom);
    step();
    step();
    i_valid = 1'b0;
    chk({tag, "_fin_pulse"}, o_finished, 0);
    chk({tag, "_busy_idle"}, o_busy, 0);
    chk({tag, "_hold"}, o_value, exp_w);
    chk({tag, "_perr_hold"}, o_parity_error, exp_perr);
    got = o_value;
  endtask

  initial begin
    logic [N-1:0] got;
    i_reset      = 1'b1;
    i_start      = 1'b0;
    i_direction  = 1'b0;
    i_iterations = '0;
    i_valid      = 1'b0;
    i_bit        = 1'b0;
    step();
    step();
    chk("rst_value", o_value, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fin", o_finished, 0);
    chk("rst_perr", o_parity_error, 0);

    // No capture without a start.
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_bit   = 1'b1;
    step();
    step();
    step();
    i_valid = 1'b0;
    chk("nostart_busy", o_busy, 0);
    chk("nostart_value", o_value, 0);

    capture(1'b1, 8, 16'h004D, 1'b0, 1'b0, "msb8", got);
    chk("msb8_b2", got, 8'hB2);

    capture(1'b0, 4, 16'h000B, 1'b1, 1'b0, "lsb4gap", got);
    chk("lsb4_0b", got, 8'h0B);

    capture(1'b1, 0, 16'hFFFF, 1'b0, 1'b0, "zero", got);
    chk("zero_val", got, 8'h00);

    capture(1'b0, 12, 16'($urandom), 1'b0, 1'b0, "clamp_lsb", got);
    capture(1'b1, 12, 16'h0FFF, 1'b0, 1'b0, "clamp_msb", got);
    chk("clamp_ff", got, 8'hFF);

    // Restart after 3 of 8 bits.
    i_start      = 1'b1;
    i_direction  = 1'b1;
    i_iterations = 8'd8;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_bit   = 1'(k % 2 == 0);
      step();
    end
    i_valid = 1'b0;
    capture(1'b1, 8, 16'h00FF, 1'b0, 1'b0, "restart", got);
    chk("restart_ff", got, 8'hFF);

    capture(1'b1, 8, 16'h004D, 1'b0, 1'b0, "par_ok", got);
    capture(1'b1, 8, 16'h004D, 1'b0, 1'b1, "par_bad", got);
    capture(1'b0, 5, 16'h0013, 1'b1, 1'b0, "par_clear", got);

    for (int r = 0; r < 24; r++) begin
      capture(1'($urandom), int'($urandom_range(0, 12)), 16'($urandom),
              1'($urandom), 1'($urandom), "rand", got);
    end

    // Reset mid-capture clears everything without a clock edge.
    i_start      = 1'b1;
    i_direction  = 1'b1;
    i_iterations = 8'd8;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_bit   = 1'b1;
      step();
    end
    i_valid = 1'b0;
    chk("pre_rst_value", o_value, 8'h0F);
    chk("pre_rst_busy", o_busy, 1);
    #1;
    i_reset = 1'b1;
    #1;
    chk("async_value", o_value, 0);
    chk("async_busy", o_busy, 0);
    chk("async_fin", o_finished, 0);
    chk("async_perr", o_parity_error, 0);
    step();
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_bit   = 1'b1;
    step();
    step();
    i_valid = 1'b0;
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_value", o_value, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
